pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Stage directly upstream of the single-cycle 8-bit datapath: owns the architectural program counter.
- Drives the datapath's PC input and registers the datapath's computed next address (PC+1 or the jump target) on each clock edge.
- Adds run/step/halt control, a PC breakpoint, a debug PC load and a retired-instruction counter, so the otherwise free-running combinational datapath can be stepped on a board or in a testbench.

Parameters:
PC_WIDTH, 8, width of program counter and addresses
RESET_VECTOR, 8'h00, PC value after reset
CNT_WIDTH, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  level; enter RUN from IDLE/HALTED
step  input  1  level; execute exactly one instruction from IDLE/HALTED
halt_req  input  1  level; stop at next edge without updating PC
bp_en  input  1  breakpoint enable
bp_addr  input  PC_WIDTH  breakpoint address
load_en  input  1  debug PC load, honoured only in IDLE/HALTED
load_addr  input  PC_WIDTH  value for debug load
next_address  input  PC_WIDTH  next PC from datapath jump mux
pc_out  output  PC_WIDTH  current PC, feeds datapath PC input
running  output  1  high while state is RUN
halted  output  1  high while state is HALTED
bp_hit  output  1  sticky; set when a breakpoint stops execution
commit  output  1  registered pulse, high the cycle after each PC update
instr_count  output  CNT_WIDTH  retired-instruction count, saturating

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - state=IDLE, pc_out=RESET_VECTOR.
  - running=0, halted=0, bp_hit=0, commit=0, instr_count=0.
  - Reset asserted mid-RUN discards the pending update; the PC returns to RESET_VECTOR at that edge.
- States: IDLE, RUN, STEP, HALTED (2-bit encoding). Outputs are registered or decoded from registered state only.
- "Update" = pc_out<=next_address, instr_count<=instr_count+1 (holds at all-ones, no wrap), commit<=1 next cycle. In every cycle without an update, commit<=0.
- IDLE and HALTED, per-edge priority:
  1. load_en: pc_out<=load_addr, state unchanged, no count.
  2. start: go to RUN and clear bp_hit; no update on this edge.
  3. step: go to STEP and clear bp_hit.
  4. Otherwise hold.
- RUN, per-edge priority:
  1. halt_req: go to HALTED, no update.
  2. bp_en && next_address==bp_addr: update, go to HALTED, set bp_hit. PC therefore rests on bp_addr, and the instruction at bp_addr has not executed.
  3. Otherwise update and stay in RUN.
- STEP:
  - halt_req: go to HALTED, no update.
  - Otherwise update and go to HALTED unconditionally.
  - Breakpoint match in STEP also sets bp_hit.
- Resuming from a breakpoint: because pc_out==bp_addr, the next update moves off bp_addr, so the breakpoint is not re-triggered immediately.
- load_en in RUN/STEP is ignored.
- PC wrap: 8'hFF -> 8'h00 comes naturally from next_address; the sequencer does no arithmetic on the PC.
- Latency: next_address is sampled at the edge and is visible on pc_out 0 cycles after that edge. The datapath is combinational, so one instruction retires per clock in RUN.
- Simultaneous start and step in IDLE: start wins.

Decomposition:
- Shared package (cpu8_pkg): PC_WIDTH, RESET_VECTOR, the state typedef/localparams (SEQ_IDLE, SEQ_RUN, SEQ_STEP, SEQ_HALTED).
- One natural sub-module: sat_counter (parameterised width, inc, clear, saturate) for instr_count.
- FSM and PC register stay in pc_sequencer.

Test Plan:
1. Reset, then start with the datapath model returning pc+1 -> after 1 idle edge, pc_out goes 00,01,02,03 on successive edges; instr_count=3; commit high each cycle after an update.
2. Run with bp_en=1, bp_addr=8'h05 -> pc_out stops at 05; halted=1, bp_hit=1, instr_count=5. Then step -> pc_out=06, bp_hit=0, halted=1, instr_count=6.
3. halt_req in RUN at pc_out=02 -> next edge pc_out stays 02, halted=1, count unchanged, commit=0.
4. In HALTED, load_en with load_addr=8'hFE, then start -> pc_out goes FE, FF, 00 (wrap); load_en asserted during RUN has no effect.
5. Reset asserted in RUN at pc_out=07 -> next edge pc_out=00, state IDLE, instr_count=0, bp_hit=0.
6. Force instr_count to all-ones, run for 3 more cycles -> count stays 16'hFFFF while pc_out keeps advancing.

Source files
------------

// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit CPU slice: address width, reset vector, sequencer states.
package cpu8_pkg;

  localparam int unsigned PC_WIDTH = 8;
  localparam logic [PC_WIDTH-1:0] RESET_VECTOR = 8'h00;
  localparam int unsigned CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_RUN    = 2'd1,
    SEQ_STEP   = 2'd2,
    SEQ_HALTED = 2'd3
  } seq_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: clear wins, otherwise increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + One;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, adds run/step/halt, breakpoint, debug load and
// a retired-instruction counter in front of the combinational datapath.
module pc_sequencer #(
  parameter int unsigned                 PC_WIDTH     = cpu8_pkg::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0]         RESET_VECTOR = cpu8_pkg::RESET_VECTOR,
  parameter int unsigned                 CNT_WIDTH    = cpu8_pkg::CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 step,
  input  logic                 halt_req,
  input  logic                 bp_en,
  input  logic [PC_WIDTH-1:0]  bp_addr,
  input  logic                 load_en,
  input  logic [PC_WIDTH-1:0]  load_addr,
  input  logic [PC_WIDTH-1:0]  next_address,
  output logic [PC_WIDTH-1:0]  pc_out,
  output logic                 running,
  output logic                 halted,
  output logic                 bp_hit,
  output logic                 commit,
  output logic [CNT_WIDTH-1:0] instr_count
);

  import cpu8_pkg::*;

  seq_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                bp_hit_q, bp_hit_d;
  logic                commit_q;
  logic                update;
  logic                bp_match;

  // Breakpoint compares the address about to be loaded, so the PC rests on bp_addr
  // before the instruction there executes.
  assign bp_match = bp_en && (next_address == bp_addr);

  // Next-state, next-PC and update decode.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    bp_hit_d = bp_hit_q;
    update   = 1'b0;
    unique case (state_q)
      SEQ_IDLE, SEQ_HALTED: begin
        if (load_en) begin
          pc_d = load_addr;
        end else if (start) begin
          state_d  = SEQ_RUN;
          bp_hit_d = 1'b0;
        end else if (step) begin
          state_d  = SEQ_STEP;
          bp_hit_d = 1'b0;
        end
      end
      SEQ_RUN: begin
        if (halt_req) begin
          state_d = SEQ_HALTED;
        end else begin
          update = 1'b1;
          pc_d   = next_address;
          if (bp_match) begin
            state_d  = SEQ_HALTED;
            bp_hit_d = 1'b1;
          end
        end
      end
      SEQ_STEP: begin
        state_d = SEQ_HALTED;
        if (!halt_req) begin
          update = 1'b1;
          pc_d   = next_address;
          if (bp_match) begin
            bp_hit_d = 1'b1;
          end
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  // State, PC, sticky breakpoint flag and commit pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SEQ_IDLE;
      pc_q     <= RESET_VECTOR;
      bp_hit_q <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      bp_hit_q <= bp_hit_d;
      commit_q <= update;
    end
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_instr_count (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (update),
    .count (instr_count)
  );

  assign pc_out  = pc_q;
  assign running = (state_q == SEQ_RUN);
  assign halted  = (state_q == SEQ_HALTED);
  assign bp_hit  = bp_hit_q;
  assign commit  = commit_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; the datapath is modelled as next_address = pc_out + 1.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, step, halt_req, bp_en, load_en;
  logic [7:0]  bp_addr, load_addr;
  logic [7:0]  next_address, pc_out;
  logic        running, halted, bp_hit, commit;
  logic [15:0] instr_count;

  // Second instance with a narrow counter to reach saturation quickly.
  logic [7:0]  s_next_address, s_pc_out;
  logic        s_running, s_halted, s_bp_hit, s_commit;
  logic [3:0]  s_instr_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign next_address   = pc_out + 8'd1;
  assign s_next_address = s_pc_out + 8'd1;

  pc_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .step         (step),
    .halt_req     (halt_req),
    .bp_en        (bp_en),
    .bp_addr      (bp_addr),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .next_address (next_address),
    .pc_out       (pc_out),
    .running      (running),
    .halted       (halted),
    .bp_hit       (bp_hit),
    .commit       (commit),
    .instr_count  (instr_count)
  );

  pc_sequencer #(
    .CNT_WIDTH (4)
  ) dut_sat (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .step         (step),
    .halt_req     (halt_req),
    .bp_en        (bp_en),
    .bp_addr      (bp_addr),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .next_address (s_next_address),
    .pc_out       (s_pc_out),
    .running      (s_running),
    .halted       (s_halted),
    .bp_hit       (s_bp_hit),
    .commit       (s_commit),
    .instr_count  (s_instr_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int unsigned pc, input int unsigned run,
                         input int unsigned hlt, input int unsigned bph, input int unsigned cmt,
                         input int unsigned cnt);
    chk({tag, ".pc"}, 32'(pc_out), pc);
    chk({tag, ".running"}, 32'(running), run);
    chk({tag, ".halted"}, 32'(halted), hlt);
    chk({tag, ".bp_hit"}, 32'(bp_hit), bph);
    chk({tag, ".commit"}, 32'(commit), cmt);
    chk({tag, ".count"}, 32'(instr_count), cnt);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; step = 1'b0; halt_req = 1'b0; bp_en = 1'b0; load_en = 1'b0;
    bp_addr = 8'h00; load_addr = 8'h00;
    tick(); tick();
    chk_all("reset", 32'h00, 0, 0, 0, 0, 0);

    // 1: start, then free run with pc+1 datapath
    reset = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("t1.start_edge", 32'h00, 1, 0, 0, 0, 0);
    tick();
    chk_all("t1.pc01", 32'h01, 1, 0, 0, 1, 1);
    tick();
    chk_all("t1.pc02", 32'h02, 1, 0, 0, 1, 2);
    tick();
    chk_all("t1.pc03", 32'h03, 1, 0, 0, 1, 3);

    // 2: breakpoint at 05, then single step off it
    bp_en = 1'b1; bp_addr = 8'h05;
    tick();
    chk_all("t2.pc04", 32'h04, 1, 0, 0, 1, 4);
    tick();
    chk_all("t2.bp", 32'h05, 0, 1, 1, 1, 5);
    tick();
    chk_all("t2.rest", 32'h05, 0, 1, 1, 0, 5);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk_all("t2.step_enter", 32'h05, 0, 0, 0, 0, 5);
    tick();
    chk_all("t2.step_done", 32'h06, 0, 1, 0, 1, 6);

    // 3: halt_req in RUN at pc 02
    bp_en = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk_all("t3.pc02", 32'h02, 1, 0, 0, 1, 2);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk_all("t3.halt", 32'h02, 0, 1, 0, 0, 2);

    // 4: debug load in HALTED, then run through the wrap; load during RUN ignored
    load_en = 1'b1; load_addr = 8'hFE;
    tick();
    load_en = 1'b0;
    chk_all("t4.load", 32'hFE, 0, 1, 0, 0, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("t4.start", 32'hFE, 1, 0, 0, 0, 2);
    load_en = 1'b1; load_addr = 8'h40;
    tick();
    chk_all("t4.pcFF", 32'hFF, 1, 0, 0, 1, 3);
    tick();
    load_en = 1'b0;
    chk_all("t4.wrap", 32'h00, 1, 0, 0, 1, 4);

    // 5: reset mid-RUN at pc 07
    for (int i = 0; i < 7; i++) tick();
    chk_all("t5.pc07", 32'h07, 1, 0, 0, 1, 11);
    reset = 1'b1;
    tick();
    chk_all("t5.reset", 32'h00, 0, 0, 0, 0, 0);
    chk("t5.sat_count_reset", 32'(s_instr_count), 0);

    // 6: saturation on the 4-bit counter instance while the PC keeps advancing
    reset = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("t6.sat_at15", 32'(s_instr_count), 32'hF);
    chk("t6.main_at15", 32'(instr_count), 15);
    for (int i = 0; i < 3; i++) tick();
    chk("t6.sat_hold", 32'(s_instr_count), 32'hF);
    chk("t6.sat_pc", 32'(s_pc_out), 32'h12);
    chk("t6.sat_commit", 32'(s_commit), 1);
    chk("t6.main_count", 32'(instr_count), 18);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
